// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low per slot, assembles a full
// 16-key frame every four slots, debounces whole frames and reports new presses.
module keypad_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row_out,
    input  logic [3:0]  col_in,
    output logic [15:0] key_status,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    localparam int DIV_W   = $clog2(SCAN_DIV);
    localparam int MATCH_W = $clog2(DEBOUNCE_FRAMES + 1);

    logic [DIV_W-1:0]   div_q;
    logic [1:0]         row_q;
    logic [11:0]        frame_q;
    logic [15:0]        last_q;
    logic [MATCH_W-1:0] match_q;
    logic [15:0]        status_q;
    logic [15:0]        prev_q;
    logic               valid_q;
    logic [3:0]         code_q;

    logic               sample;
    logic [15:0]        frame_d;
    logic [MATCH_W-1:0] match_d;
    logic [15:0]        new_press;

    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        lowest_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_idx = 4'(i);
        end
    endfunction

    always_comb begin
        sample  = (div_q == DIV_W'(SCAN_DIV - 1));
        // Rows 0-2 come from storage; the row being sampled now is spliced in,
        // so on row 3 frame_d is the complete frame.
        frame_d = {4'b0000, frame_q};
        frame_d[4*row_q +: 4] = ~col_in;
        if (frame_d == last_q) begin
            match_d = (match_q == MATCH_W'(DEBOUNCE_FRAMES)) ? match_q : match_q + 1'b1;
        end else begin
            match_d = MATCH_W'(1);
        end
        new_press = status_q & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            row_q    <= '0;
            frame_q  <= '0;
            last_q   <= '0;
            match_q  <= '0;
            status_q <= '0;
            prev_q   <= '0;
            valid_q  <= 1'b0;
            code_q   <= '0;
        end else begin
            prev_q  <= status_q;
            valid_q <= |new_press;
            if (|new_press) code_q <= lowest_idx(new_press);

            if (sample) begin
                div_q   <= '0;
                row_q   <= row_q + 2'd1;
                frame_q <= frame_d[11:0];
                if (row_q == 2'd3) begin
                    last_q  <= frame_d;
                    match_q <= match_d;
                    if (match_d == MATCH_W'(DEBOUNCE_FRAMES)) status_q <= frame_d;
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign row_out    = ~(4'b0001 << row_q);
    assign key_status = status_q;
    assign key_valid  = valid_q;
    assign key_code   = code_q;

endmodule
